// File: rtl/rs_station.sv
// Reservation station: holds dispatched instructions until both sources are ready,
// wakes sources on CDB tag match and issues up to N_WAY entries per cycle, lowest index first.
module rs_station #(
  parameter int N_WAY        = 2,
  parameter int N_RS         = 8,
  parameter int TAG_BITS     = 6,
  parameter int PAYLOAD_BITS = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY-1:0]              dis_valid,
  input  logic [N_WAY*TAG_BITS-1:0]     dis_dest_tag,
  input  logic [N_WAY*TAG_BITS-1:0]     dis_src1_tag,
  input  logic [N_WAY-1:0]              dis_src1_ready,
  input  logic [N_WAY*TAG_BITS-1:0]     dis_src2_tag,
  input  logic [N_WAY-1:0]              dis_src2_ready,
  input  logic [N_WAY*PAYLOAD_BITS-1:0] dis_payload,
  input  logic [N_WAY*TAG_BITS-1:0]     cdb_tag,
  input  logic [N_WAY-1:0]              fu_ready,
  output logic [N_WAY-1:0]              dis_accepted,
  output logic [$clog2(N_WAY):0]        free_rs_num,
  output logic [N_WAY-1:0]              issue_valid,
  output logic [N_WAY*TAG_BITS-1:0]     issue_dest_tag,
  output logic [N_WAY*TAG_BITS-1:0]     issue_src1_tag,
  output logic [N_WAY*TAG_BITS-1:0]     issue_src2_tag,
  output logic [N_WAY*PAYLOAD_BITS-1:0] issue_payload
);

  localparam int ENT_W  = (N_RS > 1) ? $clog2(N_RS) : 1;
  localparam int FCNT_W = $clog2(N_RS + 1);
  localparam int NUM_W  = $clog2(N_WAY) + 1;

  logic [N_RS-1:0]         r_valid;
  logic [N_RS-1:0]         r_rdy1;
  logic [N_RS-1:0]         r_rdy2;
  logic [TAG_BITS-1:0]     r_dest    [N_RS];
  logic [TAG_BITS-1:0]     r_src1    [N_RS];
  logic [TAG_BITS-1:0]     r_src2    [N_RS];
  logic [PAYLOAD_BITS-1:0] r_payload [N_RS];

  logic [FCNT_W-1:0] w_free_cnt;
  logic [ENT_W-1:0]  w_dis_idx [N_WAY];
  logic [ENT_W-1:0]  w_iss_idx [N_WAY];
  logic [N_WAY-1:0]  w_dis_rdy1;
  logic [N_WAY-1:0]  w_dis_rdy2;

  // A zero tag never matches, so idle CDB lanes cannot wake anything.
  function automatic logic cdbHit(input logic [TAG_BITS-1:0] tag,
                                  input logic [N_WAY*TAG_BITS-1:0] cdb);
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < N_WAY; l++) begin
      if (tag != '0 && cdb[l*TAG_BITS +: TAG_BITS] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    w_free_cnt = '0;
    for (int e = 0; e < N_RS; e++) begin
      if (!r_valid[e]) w_free_cnt = w_free_cnt + FCNT_W'(1);
    end
    if (w_free_cnt >= FCNT_W'(N_WAY)) free_rs_num = NUM_W'(N_WAY);
    else                              free_rs_num = NUM_W'(w_free_cnt);
  end

  // Only slots free in registered state are targeted, so a slot being issued this cycle is never reused.
  always_comb begin
    logic [N_RS-1:0]   taken;
    logic [FCNT_W-1:0] nAcc;
    logic              found;
    taken        = '0;
    nAcc         = '0;
    found        = 1'b0;
    dis_accepted = '0;
    w_dis_rdy1   = '0;
    w_dis_rdy2   = '0;
    for (int i = 0; i < N_WAY; i++) begin
      w_dis_idx[i]  = '0;
      w_dis_rdy1[i] = dis_src1_ready[i] || dis_src1_tag[i*TAG_BITS +: TAG_BITS] == '0 ||
                      cdbHit(dis_src1_tag[i*TAG_BITS +: TAG_BITS], cdb_tag);
      w_dis_rdy2[i] = dis_src2_ready[i] || dis_src2_tag[i*TAG_BITS +: TAG_BITS] == '0 ||
                      cdbHit(dis_src2_tag[i*TAG_BITS +: TAG_BITS], cdb_tag);
      found = 1'b0;
      if (dis_valid[i] && nAcc < w_free_cnt) begin
        dis_accepted[i] = 1'b1;
        nAcc = nAcc + FCNT_W'(1);
        for (int e = 0; e < N_RS; e++) begin
          if (!found && !r_valid[e] && !taken[e]) begin
            found        = 1'b1;
            taken[e]     = 1'b1;
            w_dis_idx[i] = ENT_W'(e);
          end
        end
      end
    end
  end

  always_comb begin
    logic [N_RS-1:0] used;
    logic            found;
    used           = '0;
    found          = 1'b0;
    issue_valid    = '0;
    issue_dest_tag = '0;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    issue_payload  = '0;
    for (int k = 0; k < N_WAY; k++) begin
      w_iss_idx[k] = '0;
      found = 1'b0;
      for (int e = 0; e < N_RS; e++) begin
        if (!found && !used[e] && r_valid[e] && r_rdy1[e] && r_rdy2[e]) begin
          found          = 1'b1;
          used[e]        = 1'b1;
          issue_valid[k] = 1'b1;
          w_iss_idx[k]   = ENT_W'(e);
          issue_dest_tag[k*TAG_BITS +: TAG_BITS]         = r_dest[e];
          issue_src1_tag[k*TAG_BITS +: TAG_BITS]         = r_src1[e];
          issue_src2_tag[k*TAG_BITS +: TAG_BITS]         = r_src2[e];
          issue_payload[k*PAYLOAD_BITS +: PAYLOAD_BITS]  = r_payload[e];
        end
      end
    end
  end

  // Wakeup, issue-clear and insert touch disjoint entries, so their order here is immaterial.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      for (int e = 0; e < N_RS; e++) begin
        r_dest[e]    <= '0;
        r_src1[e]    <= '0;
        r_src2[e]    <= '0;
        r_payload[e] <= '0;
      end
    end else begin
      for (int e = 0; e < N_RS; e++) begin
        if (r_valid[e] && cdbHit(r_src1[e], cdb_tag)) r_rdy1[e] <= 1'b1;
        if (r_valid[e] && cdbHit(r_src2[e], cdb_tag)) r_rdy2[e] <= 1'b1;
      end
      for (int k = 0; k < N_WAY; k++) begin
        if (issue_valid[k] && fu_ready[k]) r_valid[w_iss_idx[k]] <= 1'b0;
      end
      for (int i = 0; i < N_WAY; i++) begin
        if (dis_accepted[i]) begin
          r_valid[w_dis_idx[i]]   <= 1'b1;
          r_rdy1[w_dis_idx[i]]    <= w_dis_rdy1[i];
          r_rdy2[w_dis_idx[i]]    <= w_dis_rdy2[i];
          r_dest[w_dis_idx[i]]    <= dis_dest_tag[i*TAG_BITS +: TAG_BITS];
          r_src1[w_dis_idx[i]]    <= dis_src1_tag[i*TAG_BITS +: TAG_BITS];
          r_src2[w_dis_idx[i]]    <= dis_src2_tag[i*TAG_BITS +: TAG_BITS];
          r_payload[w_dis_idx[i]] <= dis_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station with N_WAY=2, N_RS=4: insert, wakeup, bypass, full, stall
// and asynchronous reset, all against hand-computed expectations.
module tb_rs_station;

  localparam int NW = 2;
  localparam int NR = 4;
  localparam int TB = 6;
  localparam int PB = 32;

  logic              clock;
  logic              reset;
  logic [NW-1:0]     dis_valid;
  logic [NW*TB-1:0]  dis_dest_tag;
  logic [NW*TB-1:0]  dis_src1_tag;
  logic [NW-1:0]     dis_src1_ready;
  logic [NW*TB-1:0]  dis_src2_tag;
  logic [NW-1:0]     dis_src2_ready;
  logic [NW*PB-1:0]  dis_payload;
  logic [NW*TB-1:0]  cdb_tag;
  logic [NW-1:0]     fu_ready;
  logic [NW-1:0]     dis_accepted;
  logic [1:0]        free_rs_num;
  logic [NW-1:0]     issue_valid;
  logic [NW*TB-1:0]  issue_dest_tag;
  logic [NW*TB-1:0]  issue_src1_tag;
  logic [NW*TB-1:0]  issue_src2_tag;
  logic [NW*PB-1:0]  issue_payload;

  int checkCount = 0;
  int failCount  = 0;

  rs_station #(.N_WAY(NW), .N_RS(NR), .TAG_BITS(TB), .PAYLOAD_BITS(PB)) dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_dest_tag(dis_dest_tag),
    .dis_src1_tag(dis_src1_tag), .dis_src1_ready(dis_src1_ready),
    .dis_src2_tag(dis_src2_tag), .dis_src2_ready(dis_src2_ready),
    .dis_payload(dis_payload), .cdb_tag(cdb_tag), .fu_ready(fu_ready),
    .dis_accepted(dis_accepted), .free_rs_num(free_rs_num),
    .issue_valid(issue_valid), .issue_dest_tag(issue_dest_tag),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_payload(issue_payload)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int lane, input logic [5:0] dest,
                               input logic [5:0] s1t, input logic s1r,
                               input logic [5:0] s2t, input logic s2r,
                               input logic [31:0] payload);
    dis_valid[lane]             = 1'b1;
    dis_dest_tag[lane*TB +: TB] = dest;
    dis_src1_tag[lane*TB +: TB] = s1t;
    dis_src1_ready[lane]        = s1r;
    dis_src2_tag[lane*TB +: TB] = s2t;
    dis_src2_ready[lane]        = s2r;
    dis_payload[lane*PB +: PB]  = payload;
  endtask

  task automatic clearDispatch;
    dis_valid      = '0;
    dis_dest_tag   = '0;
    dis_src1_tag   = '0;
    dis_src1_ready = '0;
    dis_src2_tag   = '0;
    dis_src2_ready = '0;
    dis_payload    = '0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clearDispatch();
    cdb_tag  = '0;
    fu_ready = 2'b11;
    reset    = 1'b1;
    #1;
    checkOutput("rst_free", 32'(free_rs_num), 2);
    checkOutput("rst_issue_valid", 32'(issue_valid), 0);
    checkOutput("rst_issue_dest", 32'(issue_dest_tag), 0);
    checkOutput("rst_accepted", 32'(dis_accepted), 0);
    #22 reset = 1'b0;
    tick();

    // Scenario 1: two ready instructions issue together one cycle later.
    applyStimulus(0, 6'd5, 6'd0, 1'b1, 6'd0, 1'b1, 32'hA5A5_0005);
    applyStimulus(1, 6'd6, 6'd0, 1'b1, 6'd0, 1'b1, 32'hA5A5_0006);
    #1;
    checkOutput("s1_accepted", 32'(dis_accepted), 2'b11);
    checkOutput("s1_no_early_issue", 32'(issue_valid), 0);
    tick();
    clearDispatch();
    #1;
    checkOutput("s1_issue_valid", 32'(issue_valid), 2'b11);
    checkOutput("s1_dest0", 32'(issue_dest_tag[5:0]), 5);
    checkOutput("s1_dest1", 32'(issue_dest_tag[11:6]), 6);
    checkOutput("s1_payload0", issue_payload[31:0], 32'hA5A5_0005);
    checkOutput("s1_free_during", 32'(free_rs_num), 2);
    tick();
    checkOutput("s1_issue_after", 32'(issue_valid), 0);
    checkOutput("s1_free_after", 32'(free_rs_num), 2);

    // Scenario 2: CDB wakeup becomes issuable the cycle after the broadcast.
    applyStimulus(0, 6'd7, 6'd9, 1'b0, 6'd0, 1'b0, 32'd77);
    #1;
    checkOutput("s2_accepted", 32'(dis_accepted), 2'b01);
    tick();
    clearDispatch();
    #1;
    checkOutput("s2_waiting", 32'(issue_valid), 0);
    cdb_tag = {6'd0, 6'd9};
    #1;
    checkOutput("s2_no_same_cycle_issue", 32'(issue_valid), 0);
    tick();
    cdb_tag = '0;
    #1;
    checkOutput("s2_issue_valid", 32'(issue_valid), 2'b01);
    checkOutput("s2_dest", 32'(issue_dest_tag[5:0]), 7);
    checkOutput("s2_src1", 32'(issue_src1_tag[5:0]), 9);
    tick();
    checkOutput("s2_drained", 32'(issue_valid), 0);

    // Scenario 3: a tag broadcast in the insert cycle is captured by the bypass.
    applyStimulus(0, 6'd8, 6'd0, 1'b1, 6'd12, 1'b0, 32'd88);
    cdb_tag = {6'd12, 6'd0};
    tick();
    clearDispatch();
    cdb_tag = '0;
    #1;
    checkOutput("s3_issue_valid", 32'(issue_valid), 2'b01);
    checkOutput("s3_dest", 32'(issue_dest_tag[5:0]), 8);
    tick();

    // Scenario 4: full station refuses dispatch; free count updates only after the freeing edge.
    applyStimulus(0, 6'd10, 6'd20, 1'b0, 6'd0, 1'b1, 32'd10);
    applyStimulus(1, 6'd11, 6'd21, 1'b0, 6'd0, 1'b1, 32'd11);
    tick();
    applyStimulus(0, 6'd12, 6'd22, 1'b0, 6'd0, 1'b1, 32'd12);
    applyStimulus(1, 6'd13, 6'd23, 1'b0, 6'd0, 1'b1, 32'd13);
    #1;
    checkOutput("s4_accept_second_pair", 32'(dis_accepted), 2'b11);
    tick();
    applyStimulus(0, 6'd14, 6'd0, 1'b1, 6'd0, 1'b1, 32'd14);
    applyStimulus(1, 6'd15, 6'd0, 1'b1, 6'd0, 1'b1, 32'd15);
    #1;
    checkOutput("s4_full_free", 32'(free_rs_num), 0);
    checkOutput("s4_full_accepted", 32'(dis_accepted), 0);
    tick();
    clearDispatch();
    #1;
    checkOutput("s4_state_unchanged", 32'(issue_valid), 0);
    checkOutput("s4_still_full", 32'(free_rs_num), 0);
    cdb_tag = {6'd0, 6'd22};
    tick();
    cdb_tag = '0;
    #1;
    checkOutput("s4_woken_issue", 32'(issue_valid), 2'b01);
    checkOutput("s4_woken_dest", 32'(issue_dest_tag[5:0]), 12);
    checkOutput("s4_free_before_edge", 32'(free_rs_num), 0);
    tick();
    checkOutput("s4_free_after_edge", 32'(free_rs_num), 1);
    checkOutput("s4_issue_after", 32'(issue_valid), 0);
    cdb_tag = {6'd21, 6'd20};
    tick();
    cdb_tag = {6'd0, 6'd23};
    #1;
    checkOutput("s4_pair_issue", 32'(issue_valid), 2'b11);
    checkOutput("s4_pair_dest0", 32'(issue_dest_tag[5:0]), 10);
    checkOutput("s4_pair_dest1", 32'(issue_dest_tag[11:6]), 11);
    tick();
    cdb_tag = '0;
    #1;
    checkOutput("s4_last_issue", 32'(issue_valid), 2'b01);
    checkOutput("s4_last_dest", 32'(issue_dest_tag[5:0]), 13);
    tick();
    checkOutput("s4_empty", 32'(issue_valid), 0);

    // Scenario 5: lane 0 stalls while lane 1 transfers, then lane 0 is reselected.
    fu_ready = 2'b10;
    applyStimulus(0, 6'd30, 6'd0, 1'b1, 6'd0, 1'b1, 32'd30);
    applyStimulus(1, 6'd31, 6'd0, 1'b1, 6'd0, 1'b1, 32'd31);
    tick();
    clearDispatch();
    #1;
    checkOutput("s5_issue_both", 32'(issue_valid), 2'b11);
    checkOutput("s5_dest1", 32'(issue_dest_tag[11:6]), 31);
    tick();
    checkOutput("s5_reselect_valid", 32'(issue_valid), 2'b01);
    checkOutput("s5_reselect_dest", 32'(issue_dest_tag[5:0]), 30);
    fu_ready = 2'b11;
    tick();
    checkOutput("s5_drained", 32'(issue_valid), 0);

    // Scenario 6: asynchronous reset mid-cycle with three valid entries.
    applyStimulus(0, 6'd40, 6'd50, 1'b0, 6'd0, 1'b1, 32'd40);
    applyStimulus(1, 6'd41, 6'd51, 1'b0, 6'd0, 1'b1, 32'd41);
    tick();
    clearDispatch();
    applyStimulus(0, 6'd42, 6'd0, 1'b1, 6'd0, 1'b1, 32'd42);
    tick();
    clearDispatch();
    #1;
    checkOutput("s6_free_three_valid", 32'(free_rs_num), 1);
    checkOutput("s6_issue_before_reset", 32'(issue_valid), 2'b01);
    checkOutput("s6_dest_before_reset", 32'(issue_dest_tag[5:0]), 42);
    #1 reset = 1'b1;
    #1;
    checkOutput("s6_async_issue_valid", 32'(issue_valid), 0);
    checkOutput("s6_async_free", 32'(free_rs_num), 2);
    checkOutput("s6_async_dest", 32'(issue_dest_tag), 0);
    #2 reset = 1'b0;
    tick();
    applyStimulus(0, 6'd5, 6'd0, 1'b1, 6'd0, 1'b1, 32'd5);
    applyStimulus(1, 6'd6, 6'd0, 1'b1, 6'd0, 1'b1, 32'd6);
    #1;
    checkOutput("s6_fresh_accepted", 32'(dis_accepted), 2'b11);
    tick();
    clearDispatch();
    #1;
    checkOutput("s6_fresh_issue", 32'(issue_valid), 2'b11);
    checkOutput("s6_fresh_dest0", 32'(issue_dest_tag[5:0]), 5);
    checkOutput("s6_fresh_dest1", 32'(issue_dest_tag[11:6]), 6);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
